// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one memory port between fetch and load/store, data-first with bounded fetch starvation.
module imem_dmem_arbiter #(
   parameter int AWIDTH    = 32,
   parameter int DWIDTH    = 32,
   parameter int MAX_STALL = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [AWIDTH-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DWIDTH-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [AWIDTH-1:0] d_addr_i,
   input  logic [DWIDTH-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DWIDTH-1:0] d_rdata_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   input  logic [DWIDTH-1:0] mem_data_i
);
   localparam int CW = $clog2(MAX_STALL + 1);
   typedef enum logic [1:0] {IDLE, RESP_IF, RESP_DL, RESP_DS} state_t;
   state_t state;
   logic [CW-1:0] starve_cnt;
   logic [DWIDTH-1:0] d_rdata;
   logic starved;
   assign starved = starve_cnt == CW'(MAX_STALL);
   // fetch wins only when data is absent or fetch has lost MAX_STALL times in a row
   assign if_gnt_o = rst && if_req_i && (!d_req_i || starved);
   assign d_gnt_o  = rst && d_req_i && !if_gnt_o;
   assign mem_addr_o     = if_gnt_o ? if_addr_i : d_gnt_o ? d_addr_i : '0;
   assign mem_write_en_o = d_gnt_o && d_we_i;
   assign mem_read_en_o  = if_gnt_o || (d_gnt_o && !d_we_i);
   assign mem_data_o     = mem_write_en_o ? d_wdata_i : '0;
   assign if_rvalid_o = state == RESP_IF;
   assign d_rvalid_o  = state == RESP_DL || state == RESP_DS;
   assign d_rdata_o   = state == RESP_DS ? '0 : d_rdata;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         if_rdata_o <= '0;
         d_rdata    <= '0;
      end else begin
         state      <= if_gnt_o ? RESP_IF : d_gnt_o ? (d_we_i ? RESP_DS : RESP_DL) : IDLE;
         starve_cnt <= (if_req_i && !if_gnt_o) ? (starved ? starve_cnt : starve_cnt + 1'b1) : '0;
         if (if_gnt_o) if_rdata_o <= mem_data_i;
         if (d_gnt_o && !d_we_i) d_rdata <= mem_data_i;
      end
   end
endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Shares a single memory port between the instruction-fetch requester and the load/store data requester. It arbitrates every cycle with a fixed data-first priority, bounded by an anti-starvation counter that guarantees fetch progress. It drives the memory's address/data/enable inputs and returns registered read data to the winning port one cycle after grant. It sits between fetch, the execute/memory stage, and the unified memory instance.

## Interface
- AWIDTH, 32, address width of both requesters and the memory port
- DWIDTH, 32, data width
- MAX_STALL, 3, maximum consecutive cycles a pending fetch request may lose arbitration (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- if_req_i  in  1  fetch read request, held until granted
- if_addr_i  in  AWIDTH  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle (combinational)
- if_rvalid_o  out  1  if_rdata_o valid (one-cycle pulse)
- if_rdata_o  out  DWIDTH  fetched instruction
- d_req_i  in  1  data request, held until granted
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  AWIDTH  data address
- d_wdata_i  in  DWIDTH  store data
- d_gnt_o  out  1  data request accepted this cycle (combinational)
- d_rvalid_o  out  1  load data / store acknowledge valid (one-cycle pulse)
- d_rdata_o  out  DWIDTH  load data; 0 on store acknowledge
- mem_addr_o  out  AWIDTH  memory address
- mem_data_o  out  DWIDTH  memory write data
- mem_read_en_o  out  1  memory read enable
- mem_write_en_o  out  1  memory write enable
- mem_data_i  in  DWIDTH  memory read data (combinational from mem_addr_o)

## Operation
- Arbitration (combinational, each cycle, forced to no-grant while rst=0):
  - only if_req_i → fetch granted; only d_req_i → data granted; neither → no grant.
  - both → data granted, unless starve_cnt == MAX_STALL, then fetch granted.
  - at most one of if_gnt_o/d_gnt_o is high.
- starve_cnt: width $clog2(MAX_STALL+1). Increments when if_req_i=1 and if_gnt_o=0; saturates at MAX_STALL; clears when if_gnt_o=1 or if_req_i=0.
- Memory drive:
  - fetch grant → mem_addr_o=if_addr_i, mem_read_en_o=1, mem_write_en_o=0, mem_data_o=0.
  - data load grant → mem_addr_o=d_addr_i, mem_read_en_o=1, mem_write_en_o=0, mem_data_o=0.
  - data store grant → mem_addr_o=d_addr_i, mem_data_o=d_wdata_i, mem_write_en_o=1, mem_read_en_o=0.
  - no grant → all memory outputs 0.
  - Addresses pass through unmodified; no alignment checking.
- Response FSM (state register records the grant of the previous cycle):
  - IDLE: no response owed.
  - RESP_IF: if_rvalid_o=1.
  - RESP_DL: d_rvalid_o=1, load data.
  - RESP_DS: d_rvalid_o=1, d_rdata_o=0.
  - Next state is taken from this cycle's grant: fetch→RESP_IF; load→RESP_DL; store→RESP_DS; none→IDLE. Any state may go to any state.
- Read data: on a read grant, mem_data_i is captured into the winning port's rdata register at the clock edge. Each rdata register holds its value until that port's next read grant.
- A requester may issue a new request in the same cycle its previous response is delivered.

## Timing
- Grant latency: 0 cycles (same cycle as request, subject to arbitration).
- Response latency: exactly 1 cycle after grant. Throughput: one transfer per cycle total.
- Stores commit in memory at the edge ending the grant cycle. A load granted the next cycle to the same address returns the new data.
- Fetch worst-case wait under continuous data traffic: MAX_STALL cycles, granted on cycle MAX_STALL+1.
- Reset (rst=0, asynchronous):
  - state=IDLE, starve_cnt=0, if_rdata_o=0, d_rdata_o=0, if_rvalid_o=0, d_rvalid_o=0.
  - Grants and all memory outputs are 0 during reset.
  - A response owed when reset asserts is dropped and never delivered.
- Reset release: arbitration resumes in the first cycle with rst=1.

## Test plan
- Fetch only: if_req_i=1 at if_addr_i=0x0100_0000, memory word 0x0000_0013 → if_gnt_o=1 same cycle; next cycle if_rvalid_o=1, if_rdata_o=0x0000_0013.
- Contention with MAX_STALL=3: if_req_i and d_req_i (loads) held high → d_gnt_o for 3 cycles, if_gnt_o on cycle 4, then data again. Pattern repeats every 4 cycles.
- Store then load: store 0xDEAD_BEEF to 0x0100_0040, then load 0x0100_0040 the next cycle → d_rvalid_o with d_rdata_o=0 after the store; d_rvalid_o with 0xDEAD_BEEF after the load.
- No request: all req low → all grants, mem_read_en_o, mem_write_en_o, mem_addr_o = 0; both rvalid=0 the following cycle; rdata registers unchanged.
- Reset mid-operation: assert rst=0 between a fetch grant and its response edge → if_rvalid_o stays 0, if_rdata_o=0, starve_cnt=0. After release, first request serviced normally.
